cla_add_sequencer: RTL and testbench
====================================

Name: cla_add_sequencer

Overview:
- Shares one 8-bit carry-lookahead adder slice between two requesters.
- Performs WIDTH-bit additions byte-serially, least significant byte first, chaining the carry between cycles.
- Arbitrates round-robin, captures operands with a valid/ready handshake, and returns sum, carry-out, signed overflow and requester ID on a result valid/ready port.
- Sits between operand producers and the CLA datapath, and is the sole sequencer of that slice.

Parameters:
- WIDTH, 32, operand/sum width in bits; must be a multiple of 8 and at least 8.
- NBYTES, WIDTH/8, number of byte slices per operation (derived, not overridden).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req0_valid  in  1  requester 0 has operands.
- req0_ready  out  1  requester 0 operands accepted this cycle.
- req0_a  in  WIDTH  operand A from requester 0.
- req0_b  in  WIDTH  operand B from requester 0.
- req0_cin  in  1  carry-in from requester 0.
- req1_valid, req1_ready, req1_a, req1_b, req1_cin: same as the requester 0 ports, for requester 1.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_sum  out  WIDTH  A+B+cin modulo 2^WIDTH.
- res_cout  out  1  carry out of bit WIDTH-1.
- res_ovf  out  1  two's-complement overflow.
- res_id  out  1  requester that issued this result.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: when rst_n is low at a rising edge, the block forces:
  - state = IDLE;
  - res_valid, res_sum, res_cout, res_ovf, res_id, busy all 0;
  - byte index = 0, carry register = 0;
  - round-robin pointer = requester 0 preferred.
  Reset mid-operation aborts the operation. No result is produced and the captured operands are discarded.
- States: IDLE, ADD, DONE.
- IDLE:
  - grant = pointer-preferred requester if its valid is high, otherwise the other requester if its valid is high.
  - reqN_ready is combinational: high only when state==IDLE and grant==N. At most one ready is high per cycle.
  - On the handshake edge (valid & ready):
    - capture A, B and cin;
    - capture res_id = N;
    - clear the byte index;
    - carry register = cin;
    - go to ADD;
    - set the pointer to prefer the other requester.
- ADD:
  - each cycle, byte k: {c, s} = A[8k+7:8k] + B[8k+7:8k] + carry;
  - s is written to res_sum[8k+7:8k], and the carry register is updated to c;
  - k increments.
  - After byte NBYTES-1:
    - res_cout = final carry;
    - res_ovf = (A[WIDTH-1]==B[WIDTH-1]) && (sum[WIDTH-1]!=A[WIDTH-1]);
    - go to DONE.
- DONE:
  - res_valid = 1;
  - res_sum, res_cout, res_ovf and res_id are held stable while res_ready is low;
  - on res_valid & res_ready, res_valid is cleared and the state returns to IDLE.
- Latency: res_valid rises NBYTES cycles after the accept edge (4 cycles for WIDTH=32).
- Throughput: one operation per NBYTES+2 cycles with res_ready held high.
- No new operands are accepted outside IDLE. Requesters must hold valid and data stable until ready.
- Partially built sum bits are not guaranteed before res_valid.
- res_ready high in the same cycle res_valid rises completes the transfer on that edge.
- A requester that drops valid before being granted is simply not served. The pointer is unchanged.

Test Plan:
- Reset with rst_n=0 for 2 cycles, no valids:
  - res_valid=0, busy=0, both readys 0;
  - the first later request, with both valids high, is granted to requester 0.
- req0: a=0x000000FF, b=0x00000001, cin=0:
  - res_sum=0x00000100, res_cout=0, res_ovf=0, res_id=0;
  - res_valid first high exactly 4 cycles after the accept edge.
- req1: a=0xFFFFFFFF, b=0x00000000, cin=1:
  - res_sum=0x00000000, res_cout=1, res_ovf=0, res_id=1;
  - confirms the carry ripples through all 4 byte cycles.
- req0: a=0x7FFFFFFF, b=0x00000001, cin=0:
  - res_sum=0x80000000, res_cout=0, res_ovf=1.
  - Also a=0x80000000, b=0x80000000: sum=0, cout=1, ovf=1.
- Both valids held high for 4 operations, res_ready=1:
  - served order res_id = 0,1,0,1;
  - one-hot readys, never both high.
- Backpressure and abort:
  - res_ready=0 for 5 cycles in DONE: res_valid and all result fields stay stable, both readys stay 0.
  - Then rst_n=0 for 1 cycle during ADD byte 2: res_valid never asserts for that operation.
  - The next request completes correctly from scratch.

Source files
------------

// File: rtl/cla_add_sequencer_if.sv
// Operand/result handshake bundle between two requesters, the CLA sequencer and its consumer.
interface cla_add_sequencer_if #(
    parameter int unsigned WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_cin;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_cin;

    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_sum;
    logic             res_cout;
    logic             res_ovf;
    logic             res_id;

    logic             busy;

    // Producer/consumer side
    modport master (
        output req0_valid, req0_a, req0_b, req0_cin,
        output req1_valid, req1_a, req1_b, req1_cin,
        output res_ready,
        input  req0_ready, req1_ready,
        input  res_valid, res_sum, res_cout, res_ovf, res_id, busy
    );

    // Sequencer side
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_cin,
        input  req1_valid, req1_a, req1_b, req1_cin,
        input  res_ready,
        output req0_ready, req1_ready,
        output res_valid, res_sum, res_cout, res_ovf, res_id, busy
    );
endinterface

// File: rtl/cla_add_sequencer.sv
// Byte-serial WIDTH-bit adder: two round-robin requesters share one 8-bit carry-lookahead slice.
module cla_add_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cla_add_sequencer_if.slave    bus
);
    localparam int unsigned NBYTES = WIDTH / 8;
    localparam int unsigned IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             id_q, id_d;
    logic             ptr_q, ptr_d;

    logic             gnt0_c, gnt1_c;
    logic [7:0]       a_byte_c, b_byte_c;
    logic [8:0]       slice_c;

    // 8-bit carry-lookahead slice: every carry is a flat sum of generate/propagate products
    function automatic logic [8:0] cla8(input logic [7:0] a, input logic [7:0] b, input logic ci);
        logic [7:0] g;
        logic [7:0] p;
        logic [8:0] c;
        logic       pp;
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < 8; i++) begin
            c[i+1] = g[i];
            pp     = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                c[i+1] = c[i+1] | (pp & g[j]);
                pp     = pp & p[j];
            end
            c[i+1] = c[i+1] | (pp & ci);
        end
        return {c[8], p ^ c[7:0]};
    endfunction

    // Next-state, arbitration and byte-slice datapath
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sum_d    = sum_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        id_d     = id_q;
        ptr_d    = ptr_q;
        gnt0_c   = 1'b0;
        gnt1_c   = 1'b0;
        a_byte_c = '0;
        b_byte_c = '0;
        slice_c  = '0;

        case (state_q)
            S_IDLE: begin
                if (!ptr_q) begin
                    gnt0_c = bus.req0_valid;
                    gnt1_c = !bus.req0_valid && bus.req1_valid;
                end else begin
                    gnt1_c = bus.req1_valid;
                    gnt0_c = !bus.req1_valid && bus.req0_valid;
                end
                if (gnt0_c) begin
                    a_d     = bus.req0_a;
                    b_d     = bus.req0_b;
                    carry_d = bus.req0_cin;
                    id_d    = 1'b0;
                    ptr_d   = 1'b1;
                end else if (gnt1_c) begin
                    a_d     = bus.req1_a;
                    b_d     = bus.req1_b;
                    carry_d = bus.req1_cin;
                    id_d    = 1'b1;
                    ptr_d   = 1'b0;
                end
                if (gnt0_c || gnt1_c) begin
                    idx_d   = '0;
                    state_d = S_ADD;
                end
            end

            S_ADD: begin
                for (int k = 0; k < NBYTES; k++) begin
                    if (idx_q == IDX_W'(k)) begin
                        a_byte_c = a_q[8*k +: 8];
                        b_byte_c = b_q[8*k +: 8];
                    end
                end
                slice_c = cla8(a_byte_c, b_byte_c, carry_q);
                for (int k = 0; k < NBYTES; k++) begin
                    if (idx_q == IDX_W'(k)) begin
                        sum_d[8*k +: 8] = slice_c[7:0];
                    end
                end
                carry_d = slice_c[8];
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    // slice_c[7] is sum bit WIDTH-1 on the last byte
                    cout_d  = slice_c[8];
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (slice_c[7] != a_q[WIDTH-1]);
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                if (bus.res_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            id_q    <= 1'b0;
            ptr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
        end
    end

    // Readys follow the IDLE grant; result flags decode the state register
    assign bus.req0_ready = gnt0_c;
    assign bus.req1_ready = gnt1_c;
    assign bus.res_valid  = (state_q == S_DONE);
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.res_sum    = sum_q;
    assign bus.res_cout   = cout_q;
    assign bus.res_ovf    = ovf_q;
    assign bus.res_id     = id_q;

endmodule

// File: tb/tb_cla_add_sequencer.sv
// Directed bench for cla_add_sequencer: arbitration, carry chaining, overflow, backpressure, abort.
module tb_cla_add_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    cla_add_sequencer_if #(.WIDTH(32)) bus ();

    cla_add_sequencer #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for requester id to be granted, take the accept edge, then drop its valid
    task automatic accept(input bit id, input string tag);
        bit got = 1'b0;
        int n = 0;
        while (!got && n < 20) begin
            #1;
            got = id ? bus.req1_ready : bus.req0_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (id) bus.req1_valid = 1'b0;
        else    bus.req0_valid = 1'b0;
        chk({tag, "_accept"}, 32'(got), 32'd1);
    endtask

    // From just after the accept edge: measure latency, check fields, then drain the result
    task automatic wait_result(input string tag, input logic [31:0] es, input logic ec,
                               input logic eo, input logic ei);
        int lat = 0;
        while (bus.res_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        chk({tag, "_lat"},  32'(lat), 32'd4);
        chk({tag, "_sum"},  bus.res_sum, es);
        chk({tag, "_cout"}, 32'(bus.res_cout), 32'(ec));
        chk({tag, "_ovf"},  32'(bus.res_ovf), 32'(eo));
        chk({tag, "_id"},   32'(bus.res_id), 32'(ei));
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        chk({tag, "_vclr"}, 32'(bus.res_valid), 32'd0);
        chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int          got_n;
        int          cyc;
        int          last_cyc;
        logic        ids [4];
        logic [31:0] sums [4];

        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_cin = 1'b0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_cin = 1'b0;
        bus.res_ready  = 1'b0;

        // Reset for two cycles, no valids
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_valid",  32'(bus.res_valid),  32'd0);
        chk("rst_busy",   32'(bus.busy),       32'd0);
        chk("rst_ready0", 32'(bus.req0_ready), 32'd0);
        chk("rst_ready1", 32'(bus.req1_ready), 32'd0);
        rst_n = 1'b1;
        tick();

        // Both request at once: requester 0 wins after reset
        bus.req0_a = 32'h0000_00FF; bus.req0_b = 32'h0000_0001; bus.req0_cin = 1'b0;
        bus.req1_a = 32'hFFFF_FFFF; bus.req1_b = 32'h0000_0000; bus.req1_cin = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        #1;
        chk("first_ready0", 32'(bus.req0_ready), 32'd1);
        chk("first_ready1", 32'(bus.req1_ready), 32'd0);
        accept(1'b0, "op0");
        chk("add_busy",   32'(bus.busy),       32'd1);
        chk("add_ready1", 32'(bus.req1_ready), 32'd0);
        wait_result("op0", 32'h0000_0100, 1'b0, 1'b0, 1'b0);

        // Requester 1 was left waiting; its carry ripples through every byte
        accept(1'b1, "op1");
        wait_result("op1", 32'h0000_0000, 1'b1, 1'b0, 1'b1);

        // Positive overflow
        bus.req0_a = 32'h7FFF_FFFF; bus.req0_b = 32'h0000_0001; bus.req0_cin = 1'b0;
        bus.req0_valid = 1'b1;
        accept(1'b0, "op2");
        wait_result("op2", 32'h8000_0000, 1'b0, 1'b1, 1'b0);

        // Negative overflow with carry out (from requester 1 so the pointer ends on 0)
        bus.req1_a = 32'h8000_0000; bus.req1_b = 32'h8000_0000; bus.req1_cin = 1'b0;
        bus.req1_valid = 1'b1;
        accept(1'b1, "op3");
        wait_result("op3", 32'h0000_0000, 1'b1, 1'b1, 1'b1);

        // Round robin: both valids held, consumer always ready
        bus.req0_a = 32'h0102_0304; bus.req0_b = 32'h1020_3040; bus.req0_cin = 1'b0;
        bus.req1_a = 32'h0000_FFFF; bus.req1_b = 32'h0000_0001; bus.req1_cin = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bus.res_ready  = 1'b1;
        got_n = 0;
        cyc = 0;
        last_cyc = 0;
        while (got_n < 4 && cyc < 60) begin
            tick();
            cyc++;
            chk("rr_onehot", 32'(bus.req0_ready & bus.req1_ready), 32'd0);
            if (bus.res_valid === 1'b1) begin
                ids[got_n]  = bus.res_id;
                sums[got_n] = bus.res_sum;
                if (got_n > 0) chk("rr_period", 32'(cyc - last_cyc), 32'd6);
                last_cyc = cyc;
                got_n++;
            end
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        chk("rr_count", 32'(got_n), 32'd4);
        for (int i = 0; i < got_n; i++) begin
            chk("rr_id",  32'(ids[i]), 32'(i % 2));
            chk("rr_sum", sums[i], (i % 2 == 0) ? 32'h1122_3344 : 32'h0001_0001);
        end
        tick();
        bus.res_ready = 1'b0;
        tick();

        // Backpressure: result held for 5 cycles while requester 1 waits
        bus.req0_a = 32'h1234_5678; bus.req0_b = 32'h1111_1111; bus.req0_cin = 1'b1;
        bus.req0_valid = 1'b1;
        accept(1'b0, "bp");
        bus.req1_a = 32'hFFFF_FFFF; bus.req1_b = 32'h0000_0001; bus.req1_cin = 1'b0;
        bus.req1_valid = 1'b1;
        cyc = 0;
        while (bus.res_valid !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("bp_lat", 32'(cyc), 32'd4);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", 32'(bus.res_valid), 32'd1);
            chk("bp_sum",   bus.res_sum, 32'h2345_678A);
            chk("bp_flags", {29'd0, bus.res_cout, bus.res_ovf, bus.res_id}, 32'd0);
            chk("bp_ready", 32'(bus.req0_ready | bus.req1_ready), 32'd0);
        end
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;

        // Requester 1 is granted, then reset lands on the byte-2 edge
        accept(1'b1, "abort");
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("abort_valid", 32'(bus.res_valid), 32'd0);
            chk("abort_busy",  32'(bus.busy),      32'd0);
            tick();
        end

        // Fresh operation after the abort
        bus.req1_a = 32'h00FF_00FF; bus.req1_b = 32'h0001_0001; bus.req1_cin = 1'b0;
        bus.req1_valid = 1'b1;
        accept(1'b1, "fresh");
        wait_result("fresh", 32'h0100_0100, 1'b0, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
